// File: rtl/decode_regfile.sv
// decode_regfile
// Decode stage of a 5-stage Y86-64 pipeline. Holds the architectural
// register file, derives source/destination register IDs from the D-stage
// instruction, reads operands with forwarding from E/M/W, and registers the
// decoded instruction into the E pipeline register.
//
// Ports:
//   clk, reset            pipeline clock, synchronous active-high reset
//   D_icode..D_valP       D-stage instruction fields
//   E_stall, E_bubble     E register hold / NOP-insert controls
//   e_dstE/e_valE         execute-stage forwarding source
//   M_dstE/M_valE         memory-stage ALU result forwarding source
//   M_dstM/m_valM         memory-stage load data forwarding source
//   W_dstE/W_valE,
//   W_dstM/W_valM         write-back ports (also forwarding sources)
//   d_srcA, d_srcB        combinational source IDs for the hazard unit
//   E_*                   registered E pipeline register fields
module decode_regfile #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 15,
  parameter int RSP_ID = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [3:0]        D_rA,
  input  logic [3:0]        D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [3:0]        M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [3:0]        W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP     = 4'(RSP_ID);

  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] val_a, val_b;

  // Register-ID selection from the instruction class
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      IRRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
      IIRMOVQ: begin dst_e = D_rB; end
      IRMMOVQ: begin src_a = D_rA; src_b = D_rB; end
      IMRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
      IOPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      ICALL:   begin src_b = RSP; dst_e = RSP; end
      IRET:    begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      IPUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
      IPOPQ:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
      default: ;
    endcase
  end

  assign d_srcA = src_a;
  assign d_srcB = src_b;

  // ID 15 has no storage; it always reads as zero
  assign rf_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign rf_b = (src_b == RNONE) ? '0 : regs[src_b];

  // Operand A: valP for CALL/JXX, then youngest in-flight producer first.
  // W is forwarded explicitly so a same-cycle write never exposes a stale
  // array value; W_dstM is checked before W_dstE so popq %rsp sees valM.
  always_comb begin
    val_a = rf_a;
    if (D_icode == ICALL || D_icode == IJXX) val_a = D_valP;
    else if (src_a != RNONE) begin
      if      (src_a == e_dstE) val_a = e_valE;
      else if (src_a == M_dstM) val_a = m_valM;
      else if (src_a == M_dstE) val_a = M_valE;
      else if (src_a == W_dstM) val_a = W_valM;
      else if (src_a == W_dstE) val_a = W_valE;
    end
  end

  always_comb begin
    val_b = rf_b;
    if (src_b != RNONE) begin
      if      (src_b == e_dstE) val_b = e_valE;
      else if (src_b == M_dstM) val_b = m_valM;
      else if (src_b == M_dstE) val_b = M_valE;
      else if (src_b == W_dstM) val_b = W_valM;
      else if (src_b == W_dstE) val_b = W_valE;
    end
  end

  // Register file write; the dstM write is issued last so it wins a tie
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (W_dstE != RNONE) regs[W_dstE] <= W_valE;
      if (W_dstM != RNONE) regs[W_dstM] <= W_valM;
    end
  end

  // ---- stage boundary: D -> E pipeline register ----
  always_ff @(posedge clk) begin
    if (reset || (!E_stall && E_bubble)) begin
      E_icode <= INOP;
      E_ifun  <= 4'h0;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_srcA  <= RNONE;
      E_srcB  <= RNONE;
    end else if (!E_stall) begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_valC  <= D_valC;
      E_valA  <= val_a;
      E_valB  <= val_b;
      E_dstE  <= dst_e;
      E_dstM  <= dst_m;
      E_srcA  <= src_a;
      E_srcB  <= src_b;
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
module tb_decode_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic        E_stall, E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_regfile dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [3:0] ra, input logic [3:0] rb);
    D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb;
  endtask

  initial begin
    reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    set_d(4'h6, 4'h0, 4'h0, 4'h1);
    D_valC = '0; D_valP = '0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;

    // Reset held for two cycles with an OPQ waiting in D
    step(); step();
    chk("rst_icode", E_icode, 64'h1);
    chk("rst_dstE",  E_dstE,  64'hF);
    chk("rst_dstM",  E_dstM,  64'hF);
    chk("rst_valA",  E_valA,  64'h0);
    chk("rst_valB",  E_valB,  64'h0);
    chk("rst_srcA",  E_srcA,  64'hF);
    chk("opq_d_srcA", d_srcA, 64'h0);
    chk("opq_d_srcB", d_srcB, 64'h1);

    // Write R3 then read it through the array
    reset = 1'b0;
    set_d(4'h1, 4'h0, 4'hF, 4'hF);
    W_dstE = 4'h3; W_valE = 64'h1234;
    step();
    W_dstE = 4'hF; W_valE = '0;
    set_d(4'h2, 4'h0, 4'h3, 4'h5);
    #1;
    chk("rrmov_d_srcA", d_srcA, 64'h3);
    chk("rrmov_d_srcB", d_srcB, 64'hF);
    step();
    chk("rrmov_icode", E_icode, 64'h2);
    chk("rrmov_valA",  E_valA,  64'h1234);
    chk("rrmov_dstE",  E_dstE,  64'h5);
    chk("rrmov_dstM",  E_dstM,  64'hF);
    chk("rrmov_srcA",  E_srcA,  64'h3);

    // Forwarding priority e > M.valM > W
    set_d(4'h6, 4'h1, 4'h2, 4'h2);
    e_dstE = 4'h2; e_valE = 64'hA;
    M_dstM = 4'h2; m_valM = 64'hB;
    W_dstE = 4'h2; W_valE = 64'hC;
    step();
    chk("fwd_e_valA", E_valA, 64'hA);
    chk("fwd_e_valB", E_valB, 64'hA);
    chk("fwd_e_ifun", E_ifun, 64'h1);
    e_dstE = 4'hF;
    step();
    chk("fwd_m_valA", E_valA, 64'hB);
    chk("fwd_m_valB", E_valB, 64'hB);
    M_dstM = 4'hF;
    step();
    chk("fwd_w_valA", E_valA, 64'hC);
    W_dstE = 4'hF; W_valE = '0;
    step();
    chk("rf_r2_valB", E_valB, 64'hC);

    // Same-cycle dual write to %rsp: valM wins both in forwarding and array
    set_d(4'hB, 4'h0, 4'h7, 4'hF);
    W_dstE = 4'h4; W_valE = 64'h100;
    W_dstM = 4'h4; W_valM = 64'h200;
    step();
    chk("pop_fwd_valA", E_valA, 64'h200);
    chk("pop_fwd_valB", E_valB, 64'h200);
    chk("pop_dstE",     E_dstE, 64'h4);
    chk("pop_dstM",     E_dstM, 64'h7);
    W_dstE = 4'hF; W_dstM = 4'hF;
    set_d(4'h2, 4'h0, 4'h4, 4'h6);
    step();
    chk("rsp_array", E_valA, 64'h200);

    // CALL: valA is valP, valB reads %rsp
    set_d(4'h1, 4'h0, 4'hF, 4'hF);
    W_dstE = 4'h4; W_valE = 64'h1F8;
    step();
    W_dstE = 4'hF;
    set_d(4'h8, 4'h0, 4'hF, 4'hF);
    D_valP = 64'h40; D_valC = 64'h123;
    step();
    chk("call_valA", E_valA, 64'h40);
    chk("call_valB", E_valB, 64'h1F8);
    chk("call_srcB", E_srcB, 64'h4);
    chk("call_srcA", E_srcA, 64'hF);
    chk("call_dstE", E_dstE, 64'h4);
    chk("call_dstM", E_dstM, 64'hF);
    chk("call_valC", E_valC, 64'h123);

    // JXX also selects valP
    set_d(4'h7, 4'h3, 4'hF, 4'hF);
    D_valP = 64'h88;
    step();
    chk("jxx_valA", E_valA, 64'h88);

    // Unknown icode passes through with no registers
    set_d(4'hC, 4'h5, 4'h1, 4'h2);
    step();
    chk("unk_icode", E_icode, 64'hC);
    chk("unk_valA",  E_valA,  64'h0);
    chk("unk_dstE",  E_dstE,  64'hF);
    chk("unk_srcB",  E_srcB,  64'hF);

    // Stall beats bubble, then bubble alone
    set_d(4'h6, 4'h2, 4'h0, 4'h1);
    e_dstE = 4'h0; e_valE = 64'h55;
    step();
    chk("ld_opq_icode", E_icode, 64'h6);
    chk("ld_opq_valA",  E_valA,  64'h55);
    e_dstE = 4'hF;
    set_d(4'h3, 4'h0, 4'hF, 4'h9);
    E_stall = 1'b1; E_bubble = 1'b1;
    step();
    chk("stall1_icode", E_icode, 64'h6);
    chk("stall1_valA",  E_valA,  64'h55);
    step();
    chk("stall2_icode", E_icode, 64'h6);
    chk("stall2_dstE",  E_dstE,  64'h1);
    chk("stall2_ifun",  E_ifun,  64'h2);
    E_stall = 1'b0;
    step();
    chk("bub_icode", E_icode, 64'h1);
    chk("bub_dstE",  E_dstE,  64'hF);
    chk("bub_dstM",  E_dstM,  64'hF);
    chk("bub_valA",  E_valA,  64'h0);
    E_bubble = 1'b0;
    step();
    chk("irmov_icode", E_icode, 64'h3);
    chk("irmov_dstE",  E_dstE,  64'h9);

    // Reset during a stall gives a bubble and clears the file
    E_stall = 1'b1; reset = 1'b1;
    step();
    chk("rst_stall_icode", E_icode, 64'h1);
    chk("rst_stall_dstE",  E_dstE,  64'hF);
    reset = 1'b0; E_stall = 1'b0;
    set_d(4'h2, 4'h0, 4'h4, 4'h6);
    step();
    chk("rst_cleared_r4", E_valA, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
